// File: rtl/switch_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : switch_control                                        |
// | Brief    : 5-port XY-routing switch allocator. Round-robin       |
// |            arbitration over header requests, output-port         |
// |            allocation and per-input release on end of packet.    |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module switch_control #(
  parameter int                  TAM_FLIT = 16,
  parameter logic [TAM_FLIT-1:0] address  = 16'h0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4:0]              req,
  input  logic [5*TAM_FLIT-1:0]   hdr,
  input  logic [4:0]              sender,
  output logic [4:0]              ack_h,
  output logic [4:0]              free,
  output logic [4:0]              conn,
  output logic [14:0]             mux_in,
  output logic [14:0]             mux_out
);

  localparam int METADEFLIT = TAM_FLIT / 2;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ROUTE = 2'd2,
    S_GRANT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  sel_q, sel_d;
  logic [4:0]  ack_q, ack_d;
  logic [4:0]  free_q, free_d;
  logic [4:0]  conn_q, conn_d;
  logic [14:0] mux_in_q, mux_in_d;
  logic [14:0] mux_out_q, mux_out_d;

  logic [4:0]           eff_req;
  logic                 arb_found;
  logic [2:0]           arb_sel;
  logic [2:0]           cand;
  logic [TAM_FLIT-1:0]  tgt;
  logic [2:0]           route_out;
  logic                 route_free;

  // Inputs already owning an output are not requesting a new route.
  assign eff_req = req & ~conn_q;

  // Round-robin pick: first effective request starting after the last winner.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = ptr_q;
    cand      = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      cand = 3'((int'(ptr_q) + k) % 5);
      if (!arb_found && eff_req[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  // XY routing of the selected header: resolve X first, then Y, else local.
  always_comb begin
    tgt = '0;
    for (int i = 0; i < 5; i++) begin
      if (sel_q == 3'(i)) tgt = hdr[i*TAM_FLIT +: TAM_FLIT];
    end
    if (tgt[TAM_FLIT-1:METADEFLIT] > address[TAM_FLIT-1:METADEFLIT])
      route_out = EAST;
    else if (tgt[TAM_FLIT-1:METADEFLIT] < address[TAM_FLIT-1:METADEFLIT])
      route_out = WEST;
    else if (tgt[METADEFLIT-1:0] > address[METADEFLIT-1:0])
      route_out = NORTH;
    else if (tgt[METADEFLIT-1:0] < address[METADEFLIT-1:0])
      route_out = SOUTH;
    else
      route_out = LOCAL;
    route_free = 1'b0;
    for (int o = 0; o < 5; o++) begin
      if (route_out == 3'(o)) route_free = free_q[o];
    end
  end

  // Next-state: releases first, then the FSM step (a grant never targets a
  // port or input being released in the same cycle).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    ack_d     = 5'b00000;
    free_d    = free_q;
    conn_d    = conn_q;
    mux_in_d  = mux_in_q;
    mux_out_d = mux_out_q;

    for (int i = 0; i < 5; i++) begin
      // The input granted this very cycle is shielded: its sender may not be up yet.
      if (conn_q[i] && !sender[i] && !(state_q == S_GRANT && sel_q == 3'(i))) begin
        conn_d[i] = 1'b0;
        for (int o = 0; o < 5; o++) begin
          if (mux_out_q[i*3 +: 3] == 3'(o)) free_d[o] = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|eff_req) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          sel_d   = arb_sel;
          ptr_d   = arb_sel;
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        if (route_free) begin
          state_d = S_GRANT;
          for (int i = 0; i < 5; i++) begin
            if (sel_q == 3'(i)) begin
              ack_d[i]             = 1'b1;
              conn_d[i]            = 1'b1;
              mux_out_d[i*3 +: 3]  = route_out;
            end
          end
          for (int o = 0; o < 5; o++) begin
            if (route_out == 3'(o)) begin
              free_d[o]           = 1'b0;
              mux_in_d[o*3 +: 3]  = sel_q;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any grant in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd4;
      sel_q     <= 3'd0;
      ack_q     <= 5'b00000;
      free_q    <= 5'b11111;
      conn_q    <= 5'b00000;
      mux_in_q  <= 15'd0;
      mux_out_q <= 15'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      free_q    <= free_d;
      conn_q    <= conn_d;
      mux_in_q  <= mux_in_d;
      mux_out_q <= mux_out_d;
    end
  end

  assign ack_h   = ack_q;
  assign free    = free_q;
  assign conn    = conn_q;
  assign mux_in  = mux_in_q;
  assign mux_out = mux_out_q;

endmodule
`default_nettype wire

// File: doc/switch_control.md
SWITCH_CONTROL -- requirements
Module: switch_control

Interface
REQ-001 SHALL have parameter `TAM_FLIT`, default 16: flit width in bits; `METADEFLIT` = `TAM_FLIT`/2.
REQ-002 SHALL have parameter `address`, default 16'h0000: router address {X[TAM_FLIT-1:METADEFLIT], Y[METADEFLIT-1:0]}.
REQ-003 SHALL have port `clock`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port `req`, input, 5 bits: input buffer i holds an unrouted header flit.
REQ-006 SHALL have port `hdr`, input, 5*TAM_FLIT bits: head flit of buffer i in slice [i*TAM_FLIT +: TAM_FLIT]; the target address is the full flit, {tX, tY}.
REQ-007 SHALL have port `sender`, input, 5 bits: buffer i is still transmitting its current packet; it drops after the tail flit.
REQ-008 SHALL have port `ack_h`, output, 5 bits: one-cycle routing grant to buffer i.
REQ-009 SHALL have port `free`, output, 5 bits: output port o is unallocated.
REQ-010 SHALL have port `conn`, output, 5 bits: input i owns an output port.
REQ-011 SHALL have port `mux_in`, output, 15 bits: slice [o*3 +: 3] is the input index driving output o.
REQ-012 SHALL have port `mux_out`, output, 15 bits: slice [i*3 +: 3] is the output index fed by input i.
REQ-013 SHALL use the port index encoding EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.

Function
REQ-014 SHALL implement an FSM with states IDLE, ARB, ROUTE, GRANT; `ack_h` is Moore-decoded: `ack_h`[sel]=1 only in GRANT.
REQ-015 IDLE: if any effective request (`req` & ~`conn`) is present, the FSM SHALL go to ARB; otherwise it SHALL stay in IDLE.
REQ-016 ARB: SHALL choose `sel` by round-robin.
- Scan starts at ptr+1 mod 5 and picks the first effective request.
- SHALL latch `sel` and set ptr<=sel.
- SHALL go to ROUTE.
- If the effective requests vanished, SHALL return to IDLE with ptr unchanged.
REQ-017 ROUTE: SHALL compute `out` from `hdr`[sel] by XY routing, comparing unsigned: tX>lX EAST; tX<lX WEST; else tY>lY NORTH; tY<lY SOUTH; else LOCAL.
REQ-018 ROUTE with `free`[out]=1: SHALL go to GRANT and, at the same edge, set:
- `free`[out]<=0
- `conn`[sel]<=1
- `mux_in`[out]<=sel
- `mux_out`[sel]<=out
REQ-019 ROUTE with `free`[out]=0: SHALL return to IDLE with no grant; the input is retried in a later round after the other requesters.
REQ-020 GRANT: SHALL last exactly one cycle, then go to IDLE.
REQ-021 Latency: a request seen in IDLE at cycle 0 with a free target SHALL give `ack_h` high in cycle 3; the minimum spacing between successive grants SHALL be 4 cycles.
REQ-022 Release: each cycle, every input i with `conn`[i]=1, `sender`[i]=0, and not (state=GRANT and sel=i) SHALL clear `conn`[i] and set `free`[`mux_out`[i]]<=1 at the next edge.
REQ-023 Simultaneous events: several releases SHALL be handled in the same cycle. A release and a grant on the same output port cannot coincide, because ROUTE reads registered `free`; a freed port SHALL be grantable from the following ROUTE.
REQ-024 `mux_in`/`mux_out` SHALL hold their last value after release; consumers qualify them with `free`/`conn`.
REQ-025 `req` held while `conn`[i]=1 SHALL be ignored; requesters keep `req` high until `ack_h`.

Reset
REQ-026 While `reset`=1 at a clock edge, the block SHALL set:
- state=IDLE
- ptr=4
- `ack_h`=0
- `free`=5'b11111
- `conn`=0
- `mux_in`=0
- `mux_out`=0
REQ-027 A reset mid-operation (any state, including GRANT) SHALL abort the grant; no `ack_h` pulse SHALL follow.

Verification
REQ-028 Bench SHALL cover: address=16'h0101, `req`[4]=1, hdr[4]=16'h0201 -> `ack_h`[4] in cycle 3; `free`[0]=0, `mux_in`[0]=4, `mux_out`[4]=0.
REQ-029 Bench SHALL cover: address=16'h0101, hdr[2]=16'h0101 -> out=LOCAL; `mux_out`[2]=4, `free`[4]=0.
REQ-030 Bench SHALL cover: `req`=5'b10011, all targets distinct, after reset -> grant order 0, 1, 4, each 4 cycles apart.
REQ-031 Bench SHALL cover: input 4 holds EAST; input 3 requests EAST -> no `ack_h`[3]. When `sender`[4] drops -> `free`[0]=1 next cycle, then `ack_h`[3] within 8 cycles.
REQ-032 Bench SHALL cover: inputs 0 and 1 both connected, both `sender` drop in the same cycle -> both outputs freed at one edge.
REQ-033 Bench SHALL cover: `reset` asserted during ROUTE -> no `ack_h`; all outputs at reset values next cycle.
